// File: rtl/main_driver.sv
// main_driver: host-to-engine request/response sequencer; clk, rst (async active-low), host req_valid/req_ready/req_x/req_on, engine x/on/start out and y/s/b/active/regime in, host rsp_valid/rsp_ready/rsp_y/rsp_s/rsp_regime/rsp_err, done_cnt; MAIN_DRIVER_TIMEOUT_EN adds a TIMEOUT_CYCLES busy-wait limit
module main_driver #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [1:0] req_on,
  output logic [7:0] x,
  output logic [1:0] on,
  output logic       start,
  input  logic [7:0] y,
  input  logic [2:0] s,
  input  logic       b,
  input  logic       active,
  input  logic [1:0] regime,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic [2:0] rsp_s,
  output logic [1:0] rsp_regime,
  output logic       rsp_err,
  output logic [7:0] done_cnt
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, RESP} state_t;
  state_t state, state_n;
  logic ack, ack_n, cap, tmo;
  logic unused_ok;
  assign unused_ok = active ^ (TIMEOUT_CYCLES == 0);
`ifdef MAIN_DRIVER_TIMEOUT_EN
  localparam logic [7:0] TLIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] tcnt;
`endif
  always_comb begin
    state_n = state;
    ack_n = 1'b0;
    cap = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: state_n = (req_valid && req_ready) ? LAUNCH : IDLE;
      LAUNCH: state_n = WAIT_ACK;
      WAIT_ACK: begin
        cap = !b && ack;
        ack_n = !b;
        state_n = b ? WAIT_DONE : cap ? RESP : WAIT_ACK;
      end
      WAIT_DONE: begin
        cap = !b;
        state_n = b ? WAIT_DONE : RESP;
      end
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
`ifdef MAIN_DRIVER_TIMEOUT_EN
    tmo = (state == WAIT_ACK || state == WAIT_DONE) && !cap && (tcnt + 8'd1 == TLIM);
    state_n = tmo ? RESP : state_n;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ack <= 1'b0;
      req_ready <= 1'b0;
      start <= 1'b0;
      rsp_valid <= 1'b0;
      x <= '0;
      on <= '0;
      rsp_y <= '0;
      rsp_s <= '0;
      rsp_regime <= '0;
      done_cnt <= '0;
    end else begin
      state <= state_n;
      ack <= ack_n;
      req_ready <= state_n == IDLE;
      start <= state_n == LAUNCH;
      rsp_valid <= state_n == RESP;
      if (req_valid && req_ready) begin
        x <= req_x;
        on <= req_on;
      end
      if (cap || tmo) begin
        rsp_y <= tmo ? '0 : y;
        rsp_s <= tmo ? '0 : s;
        rsp_regime <= tmo ? '0 : regime;
      end
      if (rsp_valid && rsp_ready) done_cnt <= done_cnt + 8'd1;
    end
`ifdef MAIN_DRIVER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tcnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      tcnt <= (state == WAIT_ACK || state == WAIT_DONE) ? tcnt + 8'd1 : 8'd0;
      if (cap || tmo) rsp_err <= tmo;
    end
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_main_driver.sv
// tb_main_driver: randomized self-checking bench for main_driver against a transaction-level model
module tb_main_driver;
`ifdef MAIN_DRIVER_TIMEOUT_EN
  localparam int T = 10;
  localparam bit TMO = 1'b1;
`else
  localparam int T = 255;
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic req_valid, req_ready, start, b, active, rsp_valid, rsp_ready, rsp_err;
  logic [7:0] req_x, x, y, rsp_y, done_cnt;
  logic [1:0] req_on, on, regime, rsp_regime;
  logic [2:0] s, rsp_s;
  int checks = 0, failures = 0, cyc = 0, a_cyc = 0, rv_cyc = 0, nstart = 0, n0;
  logic prev_rv = 1'b0;
  logic exp_req_ready, exp_start, exp_rsp_valid, exp_err;
  logic [7:0] exp_x, exp_y, exp_done;
  logic [1:0] exp_on, exp_reg;
  logic [2:0] exp_s;
  bit force_eng = 0;
  logic [7:0] fy;
  logic [2:0] fs;
  logic [1:0] fr;
  main_driver #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_on(req_on),
    .x(x), .on(on), .start(start), .y(y), .s(s), .b(b), .active(active), .regime(regime),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_s(rsp_s), .rsp_regime(rsp_regime),
    .rsp_err(rsp_err), .done_cnt(done_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    chk("req_ready", req_ready, exp_req_ready);
    chk("start", start, exp_start);
    chk("rsp_valid", rsp_valid, exp_rsp_valid);
    chk("x", x, exp_x);
    chk("on", on, exp_on);
    chk("rsp_y", rsp_y, exp_y);
    chk("rsp_s", rsp_s, exp_s);
    chk("rsp_regime", rsp_regime, exp_reg);
    chk("rsp_err", rsp_err, exp_err);
    chk("done_cnt", done_cnt, exp_done);
    if (start) nstart++;
    if (rsp_valid && !prev_rv) rv_cyc = cyc;
    prev_rv = rsp_valid;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rst_exp();
    {exp_req_ready, exp_start, exp_rsp_valid, exp_err} = '0;
    {exp_x, exp_y, exp_done, exp_on, exp_reg, exp_s} = '0;
  endtask
  task automatic noise();
    req_valid = 1'($urandom);
    req_x = 8'($urandom);
    req_on = 2'($urandom);
    rsp_ready = 1'($urandom);
    active = 1'($urandom);
    y = force_eng ? fy : 8'($urandom);
    s = force_eng ? fs : 3'($urandom);
    regime = force_eng ? fr : 2'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      noise();
      req_valid = 1'b0;
      b = 1'($urandom);
      step();
    end
  endtask
  // Engine capture happens on the first wait cycle after the first one that sees b=0,
  // unless the timeout limit on wait cycles is reached first.
  task automatic txn(input logic [7:0] rx, input logic [1:0] ro, input int nb, input bit all1, input int hold);
    int i, h;
    bit fin;
    logic bv, ce;
    logic [7:0] cy;
    logic [2:0] cs;
    logic [1:0] cr;
    a_cyc = cyc;
    noise();
    req_valid = 1'b1;
    req_x = rx;
    req_on = ro;
    b = 1'($urandom);
    step();
    exp_x = rx;
    exp_on = ro;
    exp_req_ready = 1'b0;
    exp_start = 1'b1;
    noise();
    b = 1'($urandom);
    step();
    exp_start = 1'b0;
    i = 0;
    fin = 0;
    {cy, cs, cr, ce} = '0;
    while (!fin) begin
      noise();
      bv = (i < nb) ? (all1 ? 1'b1 : 1'($urandom)) : 1'b0;
      b = bv;
      if (i >= 1 && !bv) begin
        cy = y; cs = s; cr = regime; ce = 1'b0; fin = 1;
      end else if (TMO && i + 1 == T) begin
        cy = '0; cs = '0; cr = '0; ce = 1'b1; fin = 1;
      end
      i++;
      step();
      if (i > 3000) begin
        $display("FAIL wait_bound got=%0d expected<=3000", i);
        $fatal(1, "wait bound exceeded");
      end
    end
    exp_rsp_valid = 1'b1;
    exp_y = cy;
    exp_s = cs;
    exp_reg = cr;
    exp_err = ce;
    h = 0;
    do begin
      noise();
      b = 1'($urandom);
      rsp_ready = h >= hold;
      h++;
      step();
    end while (!rsp_ready);
    exp_rsp_valid = 1'b0;
    exp_req_ready = 1'b1;
    exp_done = exp_done + 8'd1;
    req_valid = 1'b0;
    rsp_ready = 1'($urandom);
  endtask
  initial begin
    rst = 1'b0;
    {req_valid, req_x, req_on, y, s, b, active, regime, rsp_ready} = '0;
    rst_exp();
    step();
    step();
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b1;
    step();
    exp_req_ready = 1'b1;
    chk("ready_after_rst", req_ready, 1);
    force_eng = 1; fy = 8'h3C; fs = 3'b101; fr = 2'b01;
    n0 = nstart;
    txn(8'hA5, 2'b10, 3, 1, 0);
    chk("d1_rsp_y", rsp_y, 8'h3C);
    chk("d1_rsp_s", rsp_s, 3'b101);
    chk("d1_rsp_err", rsp_err, 0);
    chk("d1_done", done_cnt, 1);
    chk("d1_x", x, 8'hA5);
    chk("d1_on", on, 2'b10);
    chk("d1_starts", nstart - n0, 1);
    chk("d1_latency", rv_cyc - a_cyc, 6);
    fy = 8'h11;
    txn(8'h01, 2'b01, 0, 0, 0);
    chk("d2_rsp_y", rsp_y, 8'h11);
    chk("d2_latency", rv_cyc - a_cyc, 4);
    force_eng = 0;
    txn(8'hC3, 2'b11, 2, 0, 5);
    repeat (40) begin
      idle($urandom_range(0, 2));
      txn(8'($urandom), 2'($urandom), $urandom_range(0, 6), 1'($urandom), $urandom_range(0, 3));
    end
    force_eng = 1; fy = 8'h99; fs = 3'b011; fr = 2'b10;
    txn(8'h77, 2'b11, 1000, 1, 0);
    force_eng = 0;
`ifdef MAIN_DRIVER_TIMEOUT_EN
    chk("to_err", rsp_err, 1);
    chk("to_rsp_y", rsp_y, 0);
    chk("to_latency", rv_cyc - a_cyc, 12);
`else
    chk("stuck_err", rsp_err, 0);
    chk("stuck_rsp_y", rsp_y, 8'h99);
    chk("stuck_latency", rv_cyc - a_cyc, 1003);
`endif
    noise();
    req_valid = 1'b1;
    req_x = 8'h5A;
    req_on = 2'b01;
    b = 1'b1;
    step();
    exp_x = 8'h5A;
    exp_on = 2'b01;
    exp_req_ready = 1'b0;
    exp_start = 1'b1;
    noise();
    b = 1'b1;
    step();
    exp_start = 1'b0;
    noise();
    b = 1'b1;
    step();
    noise();
    b = 1'b1;
    rst = 1'b0;
    rst_exp();
    #1;
    chk("mid_rst_x", x, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_done", done_cnt, 0);
    step();
    step();
    rst = 1'b1;
    req_valid = 1'b0;
    step();
    exp_req_ready = 1'b1;
    chk("mid_rst_ready", req_ready, 1);
    txn(8'h3E, 2'b00, 1, 0, 0);
    chk("post_rst_done", done_cnt, 1);
    repeat (254) txn(8'($urandom), 2'($urandom), $urandom_range(0, 3), 1'($urandom), 0);
    chk("done_255", done_cnt, 255);
    txn(8'($urandom), 2'($urandom), 0, 0, 0);
    chk("done_wrap", done_cnt, 0);
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
